io_out_serializer: RTL
======================

IO_OUT_SERIALIZER -- requirements
Module: io_out_serializer

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per UART bit (valid range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, word entries, power of two, 2..256.
REQ-003 SHALL have parameter WORD_BYTES, default 1, bytes sent per word (1..4), taken LSB-first from out_data.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port out_data, input, 32, word to emit, sampled when out_req=1.
REQ-007 SHALL have port out_req, input, 1, single-cycle push request from the memory-access stage.
REQ-008 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-009 SHALL have port busy, output, 1, FIFO non-empty or serializer not IDLE.
REQ-010 SHALL have port overflow, output, 1, sticky flag: a push was dropped.
REQ-011 SHALL have port txd, output, 1, UART serial line, idle high.

Function
REQ-012 SHALL push out_data into the FIFO on each rising edge with out_req=1 and full=0.
REQ-013 SHALL drop a push while full=1, even if a pop occurs on that same edge, and set overflow to 1 until reset.
REQ-014 SHALL evaluate full and empty from pre-edge occupancy; simultaneous push and pop with 0<count<FIFO_DEPTH SHALL leave count unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE with FIFO non-empty, pop the head word on that edge, set byte index 0, enter START and drive txd=0 from that edge.
REQ-017 SHALL hold each bit for exactly CLK_PER_BIT cycles using a baud counter reloaded on every bit transition.
REQ-018 SHALL, in DATA, send 8 bits of the current byte LSB-first, bit counter 0..7.
REQ-019 SHALL, after DATA, go to PARITY when enabled (REQ-027), else to STOP.
REQ-020 SHALL drive txd=1 for one bit time in STOP.
REQ-021 SHALL, at the end of STOP, go to START with the next byte while byte index < WORD_BYTES-1; otherwise go to IDLE.
REQ-022 SHALL, at the end of STOP of the last byte with FIFO non-empty, go through IDLE for exactly one cycle before the next pop.
REQ-023 SHALL have a minimum latency of 2 edges from a push into an empty idle block to txd falling (push edge, then pop edge).
REQ-024 SHALL keep txd glitch-free: registered output, no combinational path from inputs.

Reset
REQ-025 SHALL, when rstn=0, asynchronously force txd=1, full=0, busy=0, overflow=0, state IDLE, FIFO count 0, and all counters to 0.
REQ-026 SHALL abandon any reset mid-frame: the partial frame is lost, and the first frame after reset release begins with a full start bit.

Configuration
REQ-027 SHALL support macro IO_OUT_PARITY_EN: when defined, send one even-parity bit (XOR of the 8 data bits) in state PARITY between DATA and STOP (frame 11 bits); when undefined, PARITY is unreachable and the frame is 10 bits.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4, WORD_BYTES=1 unless stated)
REQ-028 SHALL cover: push 32'h00000055 into an idle block -> txd falls 2 edges later, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high, busy=0 at 40 cycles after the fall.
REQ-029 SHALL cover: 6 back-to-back pushes 0x01..0x06 -> one word popped immediately, full=1 after the fifth push, the sixth dropped, overflow=1; received bytes are 01..05 with one IDLE cycle between frames.
REQ-030 SHALL cover: WORD_BYTES=4 and push 32'hA1B2C3D4 -> bytes D4, C3, B2, A1 serialized in order, no IDLE cycle between them.
REQ-031 SHALL cover: IO_OUT_PARITY_EN defined and push 8'h07 -> parity bit 1, frame 11 bits (44 cycles); with 8'h03 -> parity bit 0.
REQ-032 SHALL cover: rstn asserted during DATA bit 3 of 0x00 -> txd=1 immediately, busy=0, overflow=0; after release, push 0xFF -> a correct full frame.
REQ-033 SHALL cover: push and pop on the same edge with count=2 -> count stays 2, and output order is preserved.

Source files
------------

// File: rtl/io_out_serializer.sv
// io_out_serializer: word FIFO feeding an 8-bit UART transmitter.
// Each word is sent as WORD_BYTES bytes, LSB byte first, 8N1 framing.
// Define IO_OUT_PARITY_EN to add an even-parity bit before the stop bit.
module io_out_serializer #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16,
  parameter int WORD_BYTES  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] out_data,
  input  logic        out_req,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        txd
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(CLK_PER_BIT - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(WORD_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_n;
  logic [2:0]    next_bit;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_n;
  logic [31:0]   word_reg;
  logic [31:0]   word_n;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          txd_n;

  // Full/empty come from the occupancy before the edge, so a push while
  // full is dropped even if the serializer pops on the same edge.
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign push     = out_req && !full;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = !empty || (state != IDLE);
  assign cur_byte = word_reg[{byte_idx, 3'b000} +: 8];
  assign next_bit = bit_cnt + 3'd1;
  assign bit_end  = (baud_cnt == BAUD_LAST);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_data;
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (out_req && full) overflow <= 1'b1;
    end
  end

  // Serializer registers; txd is registered so the line never glitches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      word_reg <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_idx <= byte_n;
      word_reg <= word_n;
      txd      <= txd_n;
    end
  end

  // Next-state logic: the baud counter restarts at every bit boundary and
  // txd_n carries the value of the bit that begins on that edge
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 16'd1;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    word_n  = word_reg;
    txd_n   = txd;
    case (state)
      IDLE: begin
        baud_n = '0;
        txd_n  = 1'b1;
        if (!empty) begin
          word_n  = mem[rd_ptr];
          byte_n  = '0;
          bit_n   = '0;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          txd_n   = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
`ifdef IO_OUT_PARITY_EN
            state_n = PARITY;
            txd_n   = ^cur_byte;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n = next_bit;
            txd_n = cur_byte[next_bit];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_n  = byte_idx + 2'd1;
            bit_n   = '0;
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule
